mips_mem_responder: RTL and testbench
=====================================

// Module: mips_mem_responder
// PURPOSE
//  Memory-side responder for the single-cycle MIPS core. Serves instruction fetch (pc -> inst)
//  and data access (ALUresult/WriteDataMem/MemWrite -> ReadFromMem).
//  Owns a program-loader handshake that fills instruction memory while it holds the core in reset.
//  Sits between the core top and the board-level loader/UART.
// PARAMETERS
//  IMEM_WORDS  256  instruction memory depth in 32-bit words (power of 2)
//  DMEM_WORDS  256  data memory depth in 32-bit words (power of 2)
// PORTS
//  CLK           in   1   system clock, all state updates on rising edge
//  reset         in   1   synchronous, active-high reset
//  pc            in   32  core fetch byte address
//  inst          out  32  fetched instruction word
//  ALUresult     in   32  core data byte address
//  WriteDataMem  in   32  core store data
//  MemWrite      in   1   core store strobe
//  ReadFromMem   out  32  load data returned to core
//  ld_valid      in   1   loader word valid
//  ld_data       in   32  loader instruction word
//  ld_last       in   1   marks final loader word
//  ld_ready      out  1   responder accepts loader word this cycle
//  core_reset    out  1   drives core reset; high until program is loaded
//  mem_err       out  1   sticky access error flag
// BEHAVIOUR
//  - Clock CLK only; reset is synchronous and active-high.
//  - Reset values: state=LOAD, ld_cnt=0, ld_ready=1, core_reset=1, mem_err=0.
//    inst and ReadFromMem read 0 while not in RUN.
//  - States:
//    - LOAD: ld_ready=1. Handshake is ld_valid&&ld_ready, which writes imem[ld_cnt]<=ld_data
//      and increments ld_cnt.
//    - LOAD exits on an accepted word with ld_last=1, or on an accepted word at
//      ld_cnt==IMEM_WORDS-1 (count saturates, never wraps). Next state is CLEAR
//      (DMEM_CLEAR_EN) else RUN.
//    - CLEAR (optional): see CONFIGURATION.
//    - RUN: ld_ready=0 and core_reset=0, registered, so core_reset falls the cycle after
//      entering RUN. ld_valid is ignored. RUN is left only by reset.
//  - Fetch:
//    - Combinational read, zero cycle latency (single-cycle core):
//      inst = imem[pc[log2(IMEM_WORDS)+1:2]].
//    - pc beyond IMEM_WORDS*4, or pc[1:0]!=0, gives inst=32'h0 (NOP) and sets mem_err.
//  - Data read:
//    - Combinational: ReadFromMem = dmem[ALUresult word index].
//    - Out-of-range address gives ReadFromMem=0 and sets mem_err.
//  - Data write:
//    - On CLK edge when MemWrite && state==RUN && address aligned && in range.
//    - Misaligned or out-of-range store: write dropped, mem_err set.
//  - Read-during-write, same address: ReadFromMem shows old data that cycle, new data the
//    next cycle.
//  - mem_err is sticky and cleared only by reset. It updates only in RUN.
//  - Reset mid-operation (any state):
//    - Returns to LOAD, ld_cnt=0, core_reset=1.
//    - imem/dmem contents retained, not cleared; the loader overwrites them.
//    - A handshake in the reset cycle is not accepted.
// CONFIGURATION
//  DMEM_CLEAR_EN defined:
//    - After LOAD, state CLEAR writes dmem[clr_cnt]<=0, one word per cycle, for DMEM_WORDS
//      cycles.
//    - ld_ready=0 and core_reset=1 throughout CLEAR; then RUN.
//  DMEM_CLEAR_EN undefined:
//    - CLEAR does not exist; LOAD goes directly to RUN.
//    - dmem keeps prior contents (X after power-up).
// TESTING
//  1. Load 3 words (0x20080005, 0x20090003, 0x01095020; ld_last on the 3rd)
//     -> ld_ready drops, core_reset low one cycle after RUN entry; pc=4 gives inst=0x20090003.
//  2. ld_valid high with ld_ready stalled by reset for 1 cycle -> word not written, ld_cnt=0.
//  3. RUN, MemWrite=1, ALUresult=0x10, WriteDataMem=0xDEADBEEF -> same cycle ReadFromMem=old
//     value; next cycle 0xDEADBEEF.
//  4. Store to ALUresult=0x12 -> no write, mem_err=1; it stays 1 through further legal
//     accesses until reset.
//  5. pc=IMEM_WORDS*4 -> inst=0, mem_err=1. Load IMEM_WORDS words without ld_last
//     -> RUN after the last accepted word.
//  6. DMEM_CLEAR_EN: after load, core_reset held exactly DMEM_WORDS extra cycles; every dmem
//     read returns 0.

Source files
------------

// File: rtl/mips_mem_responder.sv
// Instruction/data memory responder for the single-cycle MIPS core, with a program loader
// that holds the core in reset. Define DMEM_CLEAR_EN to zero data memory after each load.
module mips_mem_responder #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] pc_i,
    output logic [31:0] inst_o,
    input  logic [31:0] ALUresult_i,
    input  logic [31:0] WriteDataMem_i,
    input  logic        MemWrite_i,
    output logic [31:0] ReadFromMem_o,
    input  logic        ld_valid_i,
    input  logic [31:0] ld_data_i,
    input  logic        ld_last_i,
    output logic        ld_ready_o,
    output logic        core_reset_o,
    output logic        mem_err_o
);
    localparam int IW = $clog2(IMEM_WORDS);
    localparam int DW = $clog2(DMEM_WORDS);
    localparam logic [IW-1:0] LD_MAX = IW'(IMEM_WORDS - 1);

`ifdef DMEM_CLEAR_EN
    localparam logic [DW-1:0] CLR_MAX = DW'(DMEM_WORDS - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_CLEAR,
        S_RUN
    } state_t;
`else
    typedef enum logic [1:0] {
        S_LOAD,
        S_RUN
    } state_t;
`endif

    state_t        state_q;
    logic [IW-1:0] ld_cnt_q;
    logic          ld_ready_q;
    logic          core_reset_q;
    logic          mem_err_q;
    logic          mem_err_d;
`ifdef DMEM_CLEAR_EN
    logic [DW-1:0] clr_cnt_q;
`endif

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];

    logic          running;
    logic          ld_fire;
    logic [IW-1:0] fetch_idx;
    logic          fetch_ok;
    logic [DW-1:0] data_idx;
    logic          data_in_range;
    logic          data_aligned;
    logic          store_ok;
    logic          access_err;

    assign running       = (state_q == S_RUN);
    assign ld_fire       = (state_q == S_LOAD) && ld_valid_i && ld_ready_q;

    assign fetch_idx     = pc_i[IW+1:2];
    assign fetch_ok      = (pc_i[1:0] == 2'b00) && (pc_i[31:IW+2] == '0);
    assign data_idx      = ALUresult_i[DW+1:2];
    assign data_in_range = (ALUresult_i[31:DW+2] == '0);
    assign data_aligned  = (ALUresult_i[1:0] == 2'b00);

    assign store_ok      = running && MemWrite_i && data_in_range && data_aligned;
    assign access_err    = !fetch_ok || !data_in_range || (MemWrite_i && !data_aligned);
    assign mem_err_d     = mem_err_q || (running && access_err);

    // Reads are combinational so the single-cycle core sees data in the same cycle.
    assign inst_o        = (running && fetch_ok) ? imem[fetch_idx] : 32'h0;
    assign ReadFromMem_o = (running && data_in_range) ? dmem[data_idx] : 32'h0;

    assign ld_ready_o    = ld_ready_q;
    assign core_reset_o  = core_reset_q;
    assign mem_err_o     = mem_err_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_LOAD;
            ld_cnt_q     <= '0;
            ld_ready_q   <= 1'b1;
            core_reset_q <= 1'b1;
            mem_err_q    <= 1'b0;
`ifdef DMEM_CLEAR_EN
            clr_cnt_q    <= '0;
`endif
        end else begin
            mem_err_q <= mem_err_d;
            case (state_q)
                S_LOAD: begin
                    if (ld_fire) begin
                        if (ld_cnt_q != LD_MAX) begin
                            ld_cnt_q <= ld_cnt_q + 1'b1;
                        end
                        if (ld_last_i || (ld_cnt_q == LD_MAX)) begin
                            ld_ready_q <= 1'b0;
`ifdef DMEM_CLEAR_EN
                            state_q    <= S_CLEAR;
`else
                            state_q    <= S_RUN;
`endif
                        end
                    end
                end
`ifdef DMEM_CLEAR_EN
                S_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == CLR_MAX) begin
                        state_q <= S_RUN;
                    end
                end
`endif
                // core_reset lags RUN entry by one cycle so the core leaves reset on stable memory.
                S_RUN: begin
                    core_reset_q <= 1'b0;
                end
                default: begin
                    state_q <= S_LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && ld_fire) begin
            imem[ld_cnt_q] <= ld_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
`ifdef DMEM_CLEAR_EN
            if (state_q == S_CLEAR) begin
                dmem[clr_cnt_q] <= 32'h0;
            end else if (store_ok) begin
                dmem[data_idx] <= WriteDataMem_i;
            end
`else
            if (store_ok) begin
                dmem[data_idx] <= WriteDataMem_i;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Self-checking bench for mips_mem_responder: directed loader/fetch/data steps plus random
// load/store traffic checked against an array-based memory model.
module tb_mips_mem_responder;
    localparam int IMEM_WORDS = 256;
    localparam int DMEM_WORDS = 256;
`ifdef DMEM_CLEAR_EN
    localparam int CLR_EXTRA = DMEM_WORDS;
`else
    localparam int CLR_EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = '0;
    logic [31:0] inst;
    logic [31:0] aluResult = '0;
    logic [31:0] writeData = '0;
    logic        memWrite = 1'b0;
    logic [31:0] readData;
    logic        ldValid = 1'b0;
    logic [31:0] ldData = '0;
    logic        ldLast = 1'b0;
    logic        ldReady;
    logic        coreReset;
    logic        memErr;

    int nChecks = 0;
    int nFails = 0;

    logic [31:0] imemM [IMEM_WORDS];
    logic [31:0] dmemM [DMEM_WORDS];
    bit          dmemKnown [DMEM_WORDS];

    mips_mem_responder #(
        .IMEM_WORDS(IMEM_WORDS),
        .DMEM_WORDS(DMEM_WORDS)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .pc_i          (pc),
        .inst_o        (inst),
        .ALUresult_i   (aluResult),
        .WriteDataMem_i(writeData),
        .MemWrite_i    (memWrite),
        .ReadFromMem_o (readData),
        .ld_valid_i    (ldValid),
        .ld_data_i     (ldData),
        .ld_last_i     (ldLast),
        .ld_ready_o    (ldReady),
        .core_reset_o  (coreReset),
        .mem_err_o     (memErr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the core-side inputs and let combinational outputs settle.
    task automatic applyStimulus(input logic [31:0] p, input logic [31:0] a,
                                 input logic [31:0] d, input logic w);
        pc        = p;
        aluResult = a;
        writeData = d;
        memWrite  = w;
        #1;
    endtask

    // Model of a clocked store: only aligned, in-range addresses land.
    task automatic modelStore();
        if (memWrite && aluResult[1:0] == 2'b00 && aluResult < DMEM_WORDS * 4) begin
            dmemM[aluResult / 4]     = writeData;
            dmemKnown[aluResult / 4] = 1'b1;
        end
    endtask

    task automatic doReset();
        reset   = 1'b1;
        ldValid = 1'b0;
        ldLast  = 1'b0;
        applyStimulus(32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        checkOutput("reset_ld_ready", {31'b0, ldReady}, 32'd1);
        checkOutput("reset_core_reset", {31'b0, coreReset}, 32'd1);
        checkOutput("reset_mem_err", {31'b0, memErr}, 32'd0);
        checkOutput("reset_inst_zero", inst, 32'h0);
        checkOutput("reset_read_zero", readData, 32'h0);
    endtask

    task automatic loadWords(input logic [31:0] words[$], input bit useLast);
        for (int i = 0; i < words.size(); i++) begin
            if ($urandom_range(0, 2) == 0) begin
                ldValid = 1'b0;
                tick();
            end
            ldValid = 1'b1;
            ldData  = words[i];
            ldLast  = useLast && (i == words.size() - 1);
            #1;
            checkOutput("ld_ready_in_load", {31'b0, ldReady}, 32'd1);
            checkOutput("inst_zero_in_load", inst, 32'h0);
            tick();
            imemM[i] = words[i];
        end
        ldValid = 1'b0;
        ldLast  = 1'b0;
        #1;
        checkOutput("ld_ready_after_load", {31'b0, ldReady}, 32'd0);
    endtask

    // Count cycles from final accepted word until the core is released.
    task automatic waitRun();
        int cyc = 0;
        while (coreReset === 1'b1 && cyc < 2 * DMEM_WORDS + 20) begin
            tick();
            cyc++;
        end
        checkOutput("core_reset_release_cycles", 32'(cyc), 32'(1 + CLR_EXTRA));
`ifdef DMEM_CLEAR_EN
        for (int i = 0; i < DMEM_WORDS; i++) begin
            dmemM[i]     = 32'h0;
            dmemKnown[i] = 1'b1;
        end
`endif
    endtask

    initial begin
        logic [31:0] q[$];
        int          w;
        int          pw;
        logic [31:0] d;
        logic        mw;

        for (int i = 0; i < DMEM_WORDS; i++) dmemKnown[i] = 1'b0;

        doReset();

        // A handshake offered during reset must not be accepted.
        reset   = 1'b1;
        ldValid = 1'b1;
        ldData  = 32'hAAAA_AAAA;
        tick();
        reset   = 1'b0;
        ldValid = 1'b0;
        #1;
        checkOutput("ld_ready_after_reset_hs", {31'b0, ldReady}, 32'd1);

        q.delete();
        q.push_back(32'h2008_0005);
        q.push_back(32'h2009_0003);
        q.push_back(32'h0109_5020);
        loadWords(q, 1'b1);
        checkOutput("core_reset_at_run_entry", {31'b0, coreReset}, 32'd1);
        waitRun();
        checkOutput("ld_ready_in_run", {31'b0, ldReady}, 32'd0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'(i * 4), 32'h0, 32'h0, 1'b0);
            checkOutput("fetch_loaded", inst, imemM[i]);
        end
        applyStimulus(32'h4, 32'h0, 32'h0, 1'b0);
        checkOutput("fetch_pc4", inst, 32'h2009_0003);

        // Read-during-write at 0x10: old data this cycle, new data next cycle.
        applyStimulus(32'h0, 32'h10, 32'h1111_1111, 1'b1);
        if (dmemKnown[4]) checkOutput("rdw_initial_old", readData, dmemM[4]);
        tick();
        modelStore();
        applyStimulus(32'h0, 32'h10, 32'hDEAD_BEEF, 1'b1);
        checkOutput("rdw_old_value", readData, 32'h1111_1111);
        tick();
        modelStore();
        applyStimulus(32'h0, 32'h10, 32'h0, 1'b0);
        checkOutput("rdw_new_value", readData, 32'hDEAD_BEEF);
        checkOutput("mem_err_clean", {31'b0, memErr}, 32'd0);

        for (int n = 0; n < 40; n++) begin
            w  = $urandom_range(0, 15);
            pw = $urandom_range(0, 2);
            d  = $urandom;
            mw = 1'($urandom_range(0, 1));
            applyStimulus(32'(pw * 4), 32'(w * 4), d, mw);
            checkOutput("rand_fetch", inst, imemM[pw]);
            if (dmemKnown[w]) checkOutput("rand_read", readData, dmemM[w]);
            tick();
            modelStore();
            checkOutput("rand_mem_err", {31'b0, memErr}, 32'd0);
        end

        // Misaligned store is dropped and the error flag sticks.
        applyStimulus(32'h0, 32'h12, 32'h5555_5555, 1'b1);
        tick();
        applyStimulus(32'h0, 32'h10, 32'h0, 1'b0);
        checkOutput("misaligned_mem_err", {31'b0, memErr}, 32'd1);
        checkOutput("misaligned_dropped", readData, dmemM[4]);
        for (int n = 0; n < 3; n++) begin
            applyStimulus(32'h4, 32'h14, 32'(n), 1'b1);
            tick();
            modelStore();
            checkOutput("mem_err_sticky", {31'b0, memErr}, 32'd1);
        end

        doReset();
        q.delete();
        for (int i = 0; i < IMEM_WORDS; i++) q.push_back($urandom);
        loadWords(q, 1'b0);
        waitRun();
        for (int n = 0; n < 8; n++) begin
            pw = $urandom_range(0, IMEM_WORDS - 1);
            applyStimulus(32'(pw * 4), 32'h10, 32'h0, 1'b0);
            checkOutput("full_load_fetch", inst, imemM[pw]);
        end
        applyStimulus(32'(4 * (IMEM_WORDS - 1)), 32'h10, 32'h0, 1'b0);
        checkOutput("full_load_last_word", inst, imemM[IMEM_WORDS - 1]);
        if (dmemKnown[4]) checkOutput("dmem_after_reset", readData, dmemM[4]);
        tick();
        checkOutput("mem_err_before_oor", {31'b0, memErr}, 32'd0);
        applyStimulus(32'(IMEM_WORDS * 4), 32'h0, 32'h0, 1'b0);
        checkOutput("fetch_oor_inst", inst, 32'h0);
        tick();
        checkOutput("fetch_oor_mem_err", {31'b0, memErr}, 32'd1);

        doReset();
        q.delete();
        q.push_back(32'h1234_5678);
        loadWords(q, 1'b1);
        waitRun();
        applyStimulus(32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("single_word_fetch", inst, 32'h1234_5678);
        if (dmemKnown[0]) checkOutput("dmem0_before_store", readData, dmemM[0]);
        applyStimulus(32'h0, 32'h0, 32'hCAFE_F00D, 1'b1);
        tick();
        modelStore();
        applyStimulus(32'h0, 32'(DMEM_WORDS * 4), 32'h0, 1'b0);
        checkOutput("data_oor_read_zero", readData, 32'h0);
        checkOutput("data_oor_err_pending", {31'b0, memErr}, 32'd0);
        tick();
        checkOutput("data_oor_mem_err", {31'b0, memErr}, 32'd1);
        applyStimulus(32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("dmem0_after_store", readData, dmemM[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
